mo_clk_div: RTL and testbench

//   Free-running clock divider. It produces a 50%-duty square wave S from the

---
 rtl/mo_clk_div.sv | 51 +++++
 tb/tb_mo_clk_div.sv | 106 ++++++++++
 2 files changed

// File: rtl/mo_clk_div.sv
// mo_clk_div: free-running divider producing a 50%-duty strobe S from Clo.
// S is a registered data-domain strobe sampled in the Clo domain, not a clock.
// The full S period is 2*HALF_PERIOD Clo cycles. The first rising edge of S
// comes HALF_PERIOD cycles after reset release, or after power-up.
module mo_clk_div #(
    parameter int HALF_PERIOD = 50000
) (
    input  logic Clo,
    input  logic Rst,
    output logic S
);

    // CNT_W is derived from HALF_PERIOD and is not meant to be overridden.
    localparam int CNT_W = $clog2(HALF_PERIOD) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

    // Reject a zero or negative half-period at elaboration time.
    if (HALF_PERIOD < 1) begin : g_bad_half_period
        $error("mo_clk_div: HALF_PERIOD must be >= 1");
    end

    // The declaration initialisers set the power-up value. Because of them,
    // S is 0 from time 0 even if Rst is never asserted.
    logic [CNT_W-1:0] cnt = '0;
    logic             s_q = 1'b0;

    // Count up to LAST, then wrap and toggle the strobe. Rst overrides everything.
    always_ff @(posedge Clo) begin
        // NOTE: state registers use non-blocking assignments. With them, every
        // read inside this block returns the value from before the edge.
        if (Rst) begin
            cnt <= '0;
            s_q <= 1'b0;
        end else if (cnt == LAST) begin
            cnt <= '0;
            s_q <= ~s_q;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign S = s_q;

    // The counter never leaves the range 0 .. HALF_PERIOD-1.
    a_cnt_range : assert property (@(posedge Clo) cnt <= LAST);

    // S changes only on a wrap edge or on a reset edge.
    a_s_toggle_cause : assert property (@(posedge Clo)
        (s_q != $past(s_q)) |-> (($past(cnt) == LAST) || $past(Rst)));

endmodule

// File: tb/tb_mo_clk_div.sv
// tb_mo_clk_div: directed checks of mo_clk_div at several HALF_PERIOD values.
// Four instances run from one shared Clo. Each instance has its own reset,
// and each test phase drives the reset of one instance.
// Outputs are sampled on the falling edge, half a period after the active edge.
module tb_mo_clk_div;

    logic clo = 1'b0;
    logic rst4 = 1'b1;
    logic rst1 = 1'b1;
    logic rst3 = 1'b0;
    logic rst_def = 1'b1;
    logic s4, s1, s3, s_def;

    int n_checks = 0;
    int n_errors = 0;

    mo_clk_div #(.HALF_PERIOD(4)) u_hp4    (.Clo(clo), .Rst(rst4),    .S(s4));
    mo_clk_div #(.HALF_PERIOD(1)) u_hp1    (.Clo(clo), .Rst(rst1),    .S(s1));
    mo_clk_div #(.HALF_PERIOD(3)) u_hp3    (.Clo(clo), .Rst(rst3),    .S(s3));
    mo_clk_div                    u_hp_def (.Clo(clo), .Rst(rst_def), .S(s_def));

    // Clock period is 40 ns.
    always #20 clo = ~clo;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Advance one active edge, then stop on the following falling edge.
    task automatic tick();
        @(posedge clo);
        @(negedge clo);
    endtask

    initial begin
        logic [31:0] exp_s;

        #1;
        check("powerup_s3", 32'(s3), 0);
        check("powerup_s4", 32'(s4), 0);

        // No-reset power-up with HALF_PERIOD=3. The hp4 instance stays in reset.
        for (int e = 1; e <= 6; e++) begin
            tick();
            exp_s = (e >= 3 && e < 6) ? 32'd1 : 32'd0;
            check($sformatf("noreset_hp3_e%0d", e), 32'(s3), exp_s);
            check($sformatf("inreset_hp4_e%0d", e), 32'(s4), 0);
        end

        // Release the hp4 reset. S should be high after edge 4, low after edge 8,
        // and high again after edge 12.
        rst4 = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            exp_s = 32'((e / 4) % 2);
            check($sformatf("hp4_e%0d", e), 32'(s4), exp_s);
        end

        // Mid-run reset. Move to S=1 with cnt=2, then apply Rst for one edge.
        tick();
        tick();
        check("midrst_pre_s", 32'(s4), 1);
        check("midrst_pre_cnt", 32'(u_hp4.cnt), 2);
        rst4 = 1'b1;
        tick();
        check("midrst_s", 32'(s4), 0);
        check("midrst_cnt", 32'(u_hp4.cnt), 0);
        rst4 = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            exp_s = (e == 4) ? 32'd1 : 32'd0;
            check($sformatf("midrst_rel_e%0d", e), 32'(s4), exp_s);
        end

        // HALF_PERIOD=1: S toggles on every edge, and cnt stays at 0.
        check("hp1_inreset", 32'(s1), 0);
        rst1 = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check($sformatf("hp1_e%0d", e), 32'(s1), 32'(e % 2));
            check($sformatf("hp1_cnt_e%0d", e), 32'(u_hp1.cnt), 0);
        end

        // Default HALF_PERIOD=50000. The first rise comes exactly 50000 edges
        // after release.
        check("def_inreset", 32'(s_def), 0);
        rst_def = 1'b0;
        for (int e = 1; e < 50000; e++) begin
            tick();
            if (e == 1 || e == 25000 || e == 49999)
                check($sformatf("def_low_e%0d", e), 32'(s_def), 0);
        end
        tick();
        check("def_rise_e50000", 32'(s_def), 1);
        check("def_cnt_wrap", 32'(u_hp_def.cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
